vproc_div_iter: RTL
===================

# vproc_div_iter

Iterative 32-bit radix-2 integer divider lane for the vector DIV unit. One instance per 32-bit lane, directly downstream of the DIV unit's operand-conversion stage. Receives zero- or sign-extended 32-bit dividend/divisor pairs, produces either quotient or remainder per RISC-V V semantics (including divide-by-zero and signed overflow). Uses a valid/ready handshake on both sides so the enclosing unit can stall around its multi-cycle latency.

## Interface

Parameters:
- `OP_W`, 32, operand/result width in bits (must be ≥ 2).
- `CTRL_T`, logic, opaque control type; captured on accept, returned unchanged with the result.

Ports:
- `clk_i` in 1: clock, all logic on rising edge.
- `async_rst_ni` in 1: reset, asynchronous, active-low.
- `in_valid_i` in 1: operand pair valid.
- `in_ready_o` out 1: block can accept operands.
- `in_ctrl_i` in CTRL_T: control passthrough.
- `in_op1_i` in OP_W: dividend.
- `in_op2_i` in OP_W: divisor.
- `in_signed_i` in 1: 1 = two's-complement operands, 0 = unsigned.
- `in_rem_i` in 1: 1 = return remainder, 0 = return quotient.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts result.
- `out_ctrl_o` out CTRL_T: captured control.
- `out_res_o` out OP_W: quotient or remainder.

## Operation

- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: `in_ready_o`=1. Accept when `in_valid_i` is high. Capture ctrl, rem flag, |op1|, |op2|. In unsigned mode, magnitudes are the raw operands. Set neg_q = signed & (op1[MSB]^op2[MSB]) and neg_r = signed & op1[MSB]. Clear the partial remainder (OP_W+1 bits) and the iteration counter.
- Accept, divisor == 0: load quotient = all ones, remainder = raw op1, clear neg_q/neg_r, then FIX.
- Accept, signed overflow (op1 = 1<<(OP_W-1), op2 = all ones, signed): load quotient = raw op1, remainder = 0, clear neg flags, then FIX.
- Accept, otherwise: CALC.
- CALC, one restoring step per cycle:
  - r' = {r[OP_W-1:0], q[OP_W-1]}.
  - q shifts left.
  - If r' ≥ divisor: r = r' − divisor and q LSB = 1; else r = r' and q LSB = 0.
  - Counter increments. The step taken with counter == OP_W−1 goes to FIX.
- FIX: result register = rem ? (neg_r ? −r : r) : (neg_q ? −q : q), truncated to OP_W bits. Go to DONE.
- DONE: `out_valid_o`=1. On `out_ready_i`, go to IDLE. `in_ready_o`=0 in DONE, so accept and deliver never overlap.
- `in_ready_o` is 0 in CALC, FIX and DONE. Input signals are ignored there.
- `out_res_o`/`out_ctrl_o` come from registers and are stable for the whole of DONE.

## Timing

- Reset values:
  - state = IDLE
  - `in_ready_o` = 1
  - `out_valid_o` = 0
  - `out_res_o` = 0
  - `out_ctrl_o` has no reset value and is don't-care until the first result.
- Latency, normal division: accept at edge E0. CALC edges E1..E(OP_W). FIX edge E(OP_W+1). `out_valid_o` high in the cycle after E(OP_W+1), i.e. OP_W+2 cycles after the accept cycle (34 for OP_W=32).
- Latency, divide-by-zero or overflow: `out_valid_o` high 2 cycles after the accept cycle.
- Throughput: one operation per latency+1 cycles at best. With back-to-back traffic, the next accept happens in the cycle after the DONE handshake.
- Backpressure: while `out_ready_i` is 0 in DONE, all outputs hold.
- Reset asserted at any time (CALC/FIX/DONE): state returns to IDLE immediately. The in-flight operation is discarded and `out_valid_o` drops asynchronously.

## Test plan

- Unsigned 100 / 7, quotient: output 0x0000000E after 34 cycles. Same operands with rem=1: 0x00000002.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002): quotient 0xFFFFFFFD; remainder 0xFFFFFFFF.
- Divide by zero: 5 / 0 → quotient 0xFFFFFFFF, remainder 0x00000005. Signed −5 / 0 → quotient 0xFFFFFFFF, remainder 0xFFFFFFFB. Both complete in 2 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, 2 cycles. The same operands unsigned → quotient 0, remainder 0x80000000, 34 cycles.
- Backpressure: unsigned 0xFFFFFFFF / 1, hold `out_ready_i`=0 for 5 cycles in DONE. Result 0xFFFFFFFF and ctrl stay stable, `in_ready_o` stays 0, and a waiting input is accepted the cycle after the handshake.
- Reset mid-operation: pulse `async_rst_ni` low 10 cycles into CALC. `out_valid_o`=0 and `in_ready_o`=1 immediately. A following 9 / 3 returns 0x00000003 with full normal latency.

Source files
------------

// File: rtl/vproc_div_iter.sv
// vproc_div_iter: iterative radix-2 restoring divider lane with RISC-V V
// divide-by-zero / signed-overflow semantics and valid/ready handshakes.
module vproc_div_iter #(
    parameter int  OP_W   = 32,
    parameter type CTRL_T = logic
) (
    input  logic            clk_i,
    input  logic            async_rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  CTRL_T           in_ctrl_i,
    input  logic [OP_W-1:0] in_op1_i,
    input  logic [OP_W-1:0] in_op2_i,
    input  logic            in_signed_i,
    input  logic            in_rem_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output CTRL_T           out_ctrl_o,
    output logic [OP_W-1:0] out_res_o
);
    localparam int CNT_W = $clog2(OP_W);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           r_state, w_next;
    CTRL_T            r_ctrl;
    logic [OP_W-1:0]  r_q, r_r, r_div, r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rem, r_neg_q, r_neg_r;

    logic             w_neg1, w_neg2, w_div0, w_ovf, w_ge, w_last;
    logic [OP_W-1:0]  w_abs1, w_abs2;
    logic [OP_W:0]    w_shift, w_sub;

    assign w_neg1  = in_signed_i & in_op1_i[OP_W-1];
    assign w_neg2  = in_signed_i & in_op2_i[OP_W-1];
    assign w_abs1  = w_neg1 ? -in_op1_i : in_op1_i;
    assign w_abs2  = w_neg2 ? -in_op2_i : in_op2_i;
    assign w_div0  = (in_op2_i == '0);
    assign w_ovf   = in_signed_i & (in_op1_i == {1'b1, {(OP_W-1){1'b0}}}) & (&in_op2_i);
    // The remainder always stays below the divisor, so only the shifted value needs OP_W+1 bits
    assign w_shift = {r_r, r_q[OP_W-1]};
    assign w_sub   = w_shift - {1'b0, r_div};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_last  = (r_cnt == CNT_W'(OP_W-1));

    assign in_ready_o  = (r_state == IDLE);
    assign out_valid_o = (r_state == DONE);
    assign out_res_o   = r_res;
    assign out_ctrl_o  = r_ctrl;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (in_valid_i) w_next = (w_div0 | w_ovf) ? FIX : CALC;
            CALC: if (w_last) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: if (out_ready_i) w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_state <= IDLE;
            r_res   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_rem   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: if (in_valid_i) begin
                    r_rem   <= in_rem_i;
                    r_div   <= w_abs2;
                    r_cnt   <= '0;
                    r_neg_q <= ~(w_div0 | w_ovf) & (w_neg1 ^ w_neg2);
                    r_neg_r <= ~(w_div0 | w_ovf) & w_neg1;
                    r_q     <= w_div0 ? '1 : w_ovf ? in_op1_i : w_abs1;
                    r_r     <= w_div0 ? in_op1_i : '0;
                end
                CALC: begin
                    r_q   <= {r_q[OP_W-2:0], w_ge};
                    r_r   <= w_ge ? w_sub[OP_W-1:0] : w_shift[OP_W-1:0];
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX:  r_res <= r_rem ? (r_neg_r ? -r_r : r_r) : (r_neg_q ? -r_q : r_q);
                DONE: ;
            endcase
        end
    end

    // Control carries no reset value; it is meaningless until the first result
    always_ff @(posedge clk_i) begin
        if (in_ready_o & in_valid_i) r_ctrl <= in_ctrl_i;
    end
endmodule
